// File: rtl/cpu_record_decoder.sv
// Snoops the cpu_checker character stream, extracts the numeric fields of each
// trace record and commits them as a one-cycle strobe once the checker's verdict is legal.
module cpu_record_decoder #(
  parameter logic [31:0] PC_LO   = 32'h0000_3000,
  parameter logic [31:0] PC_HI   = 32'h0000_4fff,
  parameter logic [31:0] ADDR_HI = 32'h0000_2fff,
  parameter int unsigned GRF_MAX = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic [1:0]  format_type,
  output logic        rec_valid,
  output logic [1:0]  rec_type,
  output logic [13:0] rec_time,
  output logic [31:0] rec_pc,
  output logic [4:0]  rec_grf,
  output logic [31:0] rec_addr,
  output logic [31:0] rec_data,
  output logic [2:0]  rec_err,
  output logic [15:0] rec_count
);

  localparam logic [7:0] CH_CARET = 8'h5E;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_DOLL  = 8'h24;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_HASH  = 8'h23;

  typedef enum logic [2:0] {
    S_IDLE, S_TIME, S_PC, S_GRF, S_ADDR, S_DATA, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] acc_time_q, acc_time_d, hold_time_q;
  logic [31:0] acc_pc_q, acc_pc_d, hold_pc_q;
  logic [6:0]  acc_grf_q, acc_grf_d, hold_grf_q;
  logic [31:0] acc_addr_q, acc_addr_d, hold_addr_q;
  logic [31:0] acc_data_q, acc_data_d, hold_data_q;
  logic        pending_q;

  logic        rec_valid_q;
  logic [1:0]  rec_type_q;
  logic [13:0] rec_time_q;
  logic [31:0] rec_pc_q;
  logic [4:0]  rec_grf_q;
  logic [31:0] rec_addr_q;
  logic [31:0] rec_data_q;
  logic [2:0]  rec_err_q;
  logic [15:0] rec_count_q, rec_count_d;

  logic       is_dec, is_hex;
  logic [3:0] nibble;
  logic       commit, is_reg, is_mem;
  logic       pc_err, addr_err, grf_err;

  // Character classification: decimal digits map to their low nibble, letters a-f/A-F to 10-15.
  always_comb begin
    is_dec = (char >= 8'h30) && (char <= 8'h39);
    is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66)) || ((char >= 8'h41) && (char <= 8'h46));
    nibble = is_dec ? char[3:0] : (char[3:0] + 4'd9);
  end

  always_comb begin
    state_d = state_q;
    case (char)
      CH_CARET: state_d = S_TIME;
      CH_AT:    state_d = S_PC;
      CH_DOLL:  state_d = S_GRF;
      CH_STAR:  state_d = S_ADDR;
      CH_EQ:    state_d = S_DATA;
      CH_HASH:  state_d = S_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    acc_time_d = acc_time_q;
    acc_pc_d   = acc_pc_q;
    acc_grf_d  = acc_grf_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    if (char == CH_CARET) begin
      acc_time_d = '0;
      acc_pc_d   = '0;
      acc_grf_d  = '0;
      acc_addr_d = '0;
      acc_data_d = '0;
    end else begin
      case (state_q)
        S_TIME: if (is_dec) acc_time_d = (acc_time_q * 14'd10) + {10'd0, nibble};
        S_GRF:  if (is_dec) acc_grf_d  = (acc_grf_q * 7'd10) + {3'd0, nibble};
        S_PC:   if (is_hex) acc_pc_d   = {acc_pc_q[27:0], nibble};
        S_ADDR: if (is_hex) acc_addr_d = {acc_addr_q[27:0], nibble};
        S_DATA: if (is_hex) acc_data_d = {acc_data_q[27:0], nibble};
        default: ;
      endcase
    end
  end

  // The verdict arrives one cycle after '#', so the commit works from the hold registers,
  // leaving the accumulators free for a record that starts immediately.
  always_comb begin
    is_reg      = (format_type == 2'd1);
    is_mem      = (format_type == 2'd2);
    commit      = pending_q && (is_reg || is_mem);
    pc_err      = (hold_pc_q < PC_LO) || (hold_pc_q > PC_HI) || (hold_pc_q[1:0] != 2'b00);
    addr_err    = is_mem && ((hold_addr_q > ADDR_HI) || (hold_addr_q[1:0] != 2'b00));
    grf_err     = is_reg && (32'(hold_grf_q) > GRF_MAX);
    rec_count_d = (rec_count_q == '1) ? rec_count_q : (rec_count_q + 16'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      acc_time_q  <= '0;
      acc_pc_q    <= '0;
      acc_grf_q   <= '0;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
      hold_time_q <= '0;
      hold_pc_q   <= '0;
      hold_grf_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      pending_q   <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_type_q  <= '0;
      rec_time_q  <= '0;
      rec_pc_q    <= '0;
      rec_grf_q   <= '0;
      rec_addr_q  <= '0;
      rec_data_q  <= '0;
      rec_err_q   <= '0;
      rec_count_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_time_q <= acc_time_d;
      acc_pc_q   <= acc_pc_d;
      acc_grf_q  <= acc_grf_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      pending_q  <= (char == CH_HASH);
      if (char == CH_HASH) begin
        hold_time_q <= acc_time_q;
        hold_pc_q   <= acc_pc_q;
        hold_grf_q  <= acc_grf_q;
        hold_addr_q <= acc_addr_q;
        hold_data_q <= acc_data_q;
      end
      rec_valid_q <= commit;
      if (commit) begin
        rec_type_q  <= format_type;
        rec_time_q  <= hold_time_q;
        rec_pc_q    <= hold_pc_q;
        rec_grf_q   <= is_reg ? hold_grf_q[4:0] : '0;
        rec_addr_q  <= is_mem ? hold_addr_q : '0;
        rec_data_q  <= hold_data_q;
        rec_err_q   <= {grf_err, addr_err, pc_err};
        rec_count_q <= rec_count_d;
      end
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_type  = rec_type_q;
  assign rec_time  = rec_time_q;
  assign rec_pc    = rec_pc_q;
  assign rec_grf   = rec_grf_q;
  assign rec_addr  = rec_addr_q;
  assign rec_data  = rec_data_q;
  assign rec_err   = rec_err_q;
  assign rec_count = rec_count_q;

endmodule

// File: tb/tb_cpu_record_decoder.sv
// Scoreboard bench for cpu_record_decoder: the driver pushes hand-computed expected
// records, a free-running monitor pops and compares on every rec_valid strobe.
module tb_cpu_record_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char = 8'h00;
  logic [1:0]  format_type = 2'd0;
  logic        rec_valid;
  logic [1:0]  rec_type;
  logic [13:0] rec_time;
  logic [31:0] rec_pc;
  logic [4:0]  rec_grf;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic [2:0]  rec_err;
  logic [15:0] rec_count;

  cpu_record_decoder #(
    .PC_LO(32'h0000_3000), .PC_HI(32'h0000_4fff), .ADDR_HI(32'h0000_2fff), .GRF_MAX(31)
  ) dut (
    .clk(clk), .reset(reset), .char(char), .format_type(format_type),
    .rec_valid(rec_valid), .rec_type(rec_type), .rec_time(rec_time), .rec_pc(rec_pc),
    .rec_grf(rec_grf), .rec_addr(rec_addr), .rec_data(rec_data), .rec_err(rec_err),
    .rec_count(rec_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  err;
    logic [15:0] cnt;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur_exp;
  exp_t        last_exp;
  int unsigned strobe_cyc[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  logic [15:0] exp_count = '0;
  logic [1:0]  cur_verdict = 2'd0;
  logic [1:0]  ft_pend = 2'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation, including its cycle.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rec_valid === 1'b1) begin
      strobe_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got rec_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("rec_type", 32'(rec_type), 32'(e.typ));
        chk("rec_time", 32'(rec_time), 32'(e.t));
        chk("rec_pc", rec_pc, e.pc);
        chk("rec_grf", 32'(rec_grf), 32'(e.grf));
        chk("rec_addr", rec_addr, e.addr);
        chk("rec_data", rec_data, e.data);
        chk("rec_err", 32'(rec_err), 32'(e.err));
        chk("rec_count", 32'(rec_count), 32'(e.cnt));
      end
    end
  end

  // One character per cycle; the checker verdict is presented the cycle after '#'.
  task automatic drive(input logic [7:0] c);
    @(negedge clk);
    char = c;
    format_type = ft_pend;
    ft_pend = 2'd0;
    if (c == 8'h23) begin
      ft_pend = cur_verdict;
      if (cur_verdict == 2'd1 || cur_verdict == 2'd2) begin
        exp_count = (exp_count == 16'hffff) ? exp_count : exp_count + 16'd1;
        cur_exp.cnt = exp_count;
        cur_exp.cyc = cyc + 2;
        sb.push_back(cur_exp);
        last_exp = cur_exp;
      end
    end
  endtask

  task automatic send_rec(input string s, input logic [1:0] v, input int gap,
                          input logic [13:0] t, input logic [31:0] pc, input logic [4:0] grf,
                          input logic [31:0] addr, input logic [31:0] data, input logic [2:0] err);
    cur_verdict = v;
    cur_exp.typ = v;
    cur_exp.t = t;
    cur_exp.pc = pc;
    cur_exp.grf = grf;
    cur_exp.addr = addr;
    cur_exp.data = data;
    cur_exp.err = err;
    for (int i = 0; i < s.len(); i++) drive(s[i]);
    for (int i = 0; i < gap; i++) drive(8'h0a);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(rec_valid), 0);
    chk({tag, "_type"}, 32'(rec_type), 0);
    chk({tag, "_time"}, 32'(rec_time), 0);
    chk({tag, "_pc"}, rec_pc, 0);
    chk({tag, "_grf"}, 32'(rec_grf), 0);
    chk({tag, "_addr"}, rec_addr, 0);
    chk({tag, "_data"}, rec_data, 0);
    chk({tag, "_err"}, 32'(rec_err), 0);
    chk({tag, "_count"}, 32'(rec_count), 0);
  endtask

  initial begin
    int unsigned n0;
    string partial;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    send_rec("^242@000030f4: $31 <= 12345678#", 2'd1, 1, 14'd242, 32'h30f4, 5'd31, 32'h0, 32'h12345678, 3'b000);
    wait_drain();

    n0 = strobe_cyc.size();
    send_rec("^338@00003130: *00000088 <= Ffffb528#", 2'd2, 1, 14'd338, 32'h3130, 5'd0, 32'h88, 32'hffffb528, 3'b000);
    send_rec("^338@00003130: *00000088 <= Ffffb528#", 2'd2, 1, 14'd338, 32'h3130, 5'd0, 32'h88, 32'hffffb528, 3'b000);
    wait_drain();
    if (strobe_cyc.size() >= n0 + 2) chk("mem_pair_spacing", strobe_cyc[n0 + 1] - strobe_cyc[n0], 38);
    else begin
      n_checks++;
      $display("FAIL mem_pair_spacing: got %0d strobes expected 2", strobe_cyc.size() - n0);
    end

    // Rejected verdicts (0 and 3): outputs must keep the last committed record.
    send_rec("^242@000030f4: $31 <=   ab123215 #", 2'd0, 1, '0, '0, '0, '0, '0, '0);
    send_rec("^242@000030f4: $31 <=   ab123215 #", 2'd3, 3, '0, '0, '0, '0, '0, '0);
    chk("drop_type", 32'(rec_type), 32'(last_exp.typ));
    chk("drop_time", 32'(rec_time), 32'(last_exp.t));
    chk("drop_addr", rec_addr, last_exp.addr);
    chk("drop_data", rec_data, last_exp.data);
    chk("drop_count", 32'(rec_count), 32'(exp_count));

    // Error flags, back-to-back records with '^' on the verdict edge, mid-record restart, truncation.
    send_rec("^1@00002ffe: $32 <= 1#", 2'd1, 1, 14'd1, 32'h2ffe, 5'd0, 32'h0, 32'h1, 3'b101);
    send_rec("^5@00003000: *00003001 <= 0#", 2'd2, 0, 14'd5, 32'h3000, 5'd0, 32'h3001, 32'h0, 3'b010);
    send_rec("^99@0000^7@00003004: $1 <= a#", 2'd1, 0, 14'd7, 32'h3004, 5'd1, 32'h0, 32'ha, 3'b000);
    send_rec("^3@00005000: *00002ffc <= 5#", 2'd2, 0, 14'd3, 32'h5000, 5'd0, 32'h2ffc, 32'h5, 3'b001);
    send_rec("^16384@00004ffc: $0 <= 0#", 2'd1, 1, 14'd0, 32'h4ffc, 5'd0, 32'h0, 32'h0, 3'b000);
    wait_drain();

    // Reset in the middle of a record: no strobe for the partial record.
    partial = "^242@0000";
    for (int i = 0; i < partial.len(); i++) drive(partial[i]);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_count = '0;
    repeat (2) @(negedge clk);
    check_all_zero("midreset_hold");
    reset = 1'b0;
    send_rec("^242@000030f4: $31 <= 12345678#", 2'd1, 1, 14'd242, 32'h30f4, 5'd31, 32'h0, 32'h12345678, 3'b000);
    wait_drain();
    chk("count_after_reset", 32'(rec_count), 1);

    // Saturation: preload just below the ceiling, then commit two more.
    @(negedge clk);
    force dut.rec_count_q = 16'hfffe;
    @(negedge clk);
    release dut.rec_count_q;
    exp_count = 16'hfffe;
    chk("preload_count", 32'(rec_count), 32'hfffe);
    send_rec("^242@000030f4: $31 <= 12345678#", 2'd1, 1, 14'd242, 32'h30f4, 5'd31, 32'h0, 32'h12345678, 3'b000);
    send_rec("^242@000030f4: $31 <= 12345678#", 2'd1, 1, 14'd242, 32'h30f4, 5'd31, 32'h0, 32'h12345678, 3'b000);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("sat_count", 32'(rec_count), 32'hffff);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_record_decoder.md
Name: cpu_record_decoder

Overview:
- Sits downstream of cpu_checker and snoops the same character stream in parallel with it.
- Extracts the numeric fields of each trace record:
  - register write: "^time@pc: $grf <= data#"
  - memory write: "^time@pc: *addr <= data#"
- Commits those fields only when cpu_checker reports a legal format_type.
- Emits a one-cycle record strobe with range/alignment error flags and a committed-record counter for the downstream scoreboard.

Parameters:
- PC_LO, 32'h0000_3000, lowest legal pc (inclusive)
- PC_HI, 32'h0000_4fff, highest legal pc (inclusive)
- ADDR_HI, 32'h0000_2fff, highest legal memory address (inclusive)
- GRF_MAX, 31, highest legal register number

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- char  in  8  ASCII character, one per cycle, same value cpu_checker samples
- format_type  in  2  cpu_checker output: 0 invalid, 1 register record, 2 memory record, 3 treated as invalid
- rec_valid  out  1  one-cycle strobe: a record was committed
- rec_type  out  2  1 = register, 2 = memory
- rec_time  out  14  decimal time field
- rec_pc  out  32  hex pc field
- rec_grf  out  5  register number (low 5 bits); 0 for memory records
- rec_addr  out  32  hex address; 0 for register records
- rec_data  out  32  hex data field
- rec_err  out  3  bit0 pc error, bit1 addr error, bit2 grf error
- rec_count  out  16  committed records since reset, saturates at 16'hffff

Behaviour:
- Reset (async): all outputs, accumulators, hold registers and the pending flag go to 0; FSM goes to S_IDLE.
- FSM states: S_IDLE, S_TIME, S_PC, S_GRF, S_ADDR, S_DATA, S_DONE.
- Transitions are evaluated on every sampled char, from any state:
  - '^' -> S_TIME; clear acc_time, acc_pc, acc_grf, acc_addr, acc_data.
  - '@' -> S_PC.
  - '$' -> S_GRF.
  - '*' -> S_ADDR.
  - '=' -> S_DATA.
  - '#' -> S_DONE.
  - All other chars leave the state unchanged.
- Accumulation (only in the matching state; non-digit chars, including spaces, are ignored):
  - S_TIME: acc_time = acc_time*10 + d for '0'-'9'; 14-bit, truncating.
  - S_GRF: acc_grf = acc_grf*10 + d; 7-bit, truncating.
  - S_PC, S_ADDR, S_DATA: acc = {acc[27:0], nibble} for '0'-'9', 'a'-'f', 'A'-'F'. Any other char is ignored, so leading spaces in data are harmless.
- '#' sampled at edge k:
  - Copy all five accumulators into hold registers.
  - Set pending = 1 for exactly one cycle.
  - '#' in any state, including S_IDLE, does this.
- Edge k+1:
  - cpu_checker presents the verdict for that record during the cycle after edge k, so the decoder samples format_type at edge k+1.
  - If pending and format_type is 1 or 2: load rec_* from hold registers; rec_type = format_type; force the unused grf/addr output to 0; compute rec_err; rec_valid = 1; rec_count += 1 unless already 16'hffff.
  - Otherwise: rec_valid = 0 and rec_* are unchanged.
  - Latency: rec_valid is high in the cycle after edge k+1, i.e. the second cycle after '#' is sampled.
- Hold registers guarantee a '^' at edge k+1 (back-to-back records) does not corrupt the commit.
- rec_valid is high for one cycle only. rec_* hold their values until the next commit.
- Error rules, each evaluated against the committed value:
  - pc_err = pc < PC_LO, or pc > PC_HI, or pc[1:0] != 0.
  - addr_err (type 2 only) = addr > ADDR_HI, or addr[1:0] != 0.
  - grf_err (type 1 only) = acc_grf > GRF_MAX, compared on the full 7 bits.
- Simultaneous events: pending commit and a new '^' on the same edge are both honoured.
- Reset mid-record: the partial record is discarded; no strobe follows.
- '^' mid-record restarts field capture.
- Both format_type == 0 and format_type == 3 drop the record silently.

Test Plan:
- Register record: "^242@000030f4: $31 <= 12345678#".
  - Response: single rec_valid, rec_type=1, rec_time=242, rec_pc=0x000030f4, rec_grf=31, rec_addr=0, rec_data=0x12345678, rec_err=0, rec_count=1.
- Memory record: "^338@00003130: *00000088 <= Ffffb528#" sent back-to-back with a second identical record.
  - Response: two strobes exactly 38 cycles apart, each with rec_type=2, rec_addr=0x88, rec_data=0xffffb528, rec_err=0; rec_count=2.
- Invalid record: "^242@000030f4: $31 <=   ab123215 #" with the bench's cpu_checker producing format_type=0.
  - Response: no rec_valid; rec_* keep the previous values; rec_count unchanged.
- Error flags:
  - "^1@00002ffe: $32 <= 1#" -> rec_err=3'b101 (pc range/alignment plus grf), rec_grf=0 (low 5 bits of 32).
  - "^5@00003000: *00003001 <= 0#" -> rec_err=3'b010.
- Reset mid-record: assert reset after "^242@0000" for 2 cycles, then send a full valid record.
  - Response: all outputs read 0 during reset; exactly one strobe afterwards, for the second record only; rec_count=1.
- Saturation: force 65536 valid records (or preload via hierarchical force).
  - Response: rec_count stays at 16'hffff while rec_valid still pulses.
